cache_bus_arbiter: RTL and testbench

Shares the single AXI4 master port of the core between the instruction cache (read-only line fills) and the data cache (line fills and line write-backs).
- Accepts one whole-line request at a time and issues it as one INCR burst.
- Streams beats between the bus and the granted cache, then signals completion.
- Sits between both cache instances and the top-level m_axi_* ports.

---
 rtl/bus_arb_pkg.sv | 7 +
 rtl/axi_beat_counter.sv | 22 ++
 rtl/cache_bus_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and AXI constants for the cache bus arbiter.
package bus_arb_pkg;
    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_e;
    typedef enum logic {OWN_IC, OWN_DC} owner_e;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/axi_beat_counter.sv
// axi_beat_counter: per-burst beat counter with clear, increment and last-beat flag.
module axi_beat_counter #(
    parameter int BEATS = 4,
    parameter int CW    = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);
    logic [CW-1:0] count_q, count_d;

    always_comb count_d = clear ? '0 : inc ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign last = count_q == CW'(BEATS - 1);
endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one AXI4 master between I-cache fills and D-cache fills/write-backs.
// Define ROUND_ROBIN_EN to alternate ties between caches; otherwise the D-cache always wins ties.
module cache_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 4,
    parameter int IC_ID      = 0,
    parameter int DC_ID      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ic_req_valid,
    input  logic [ADDR_WIDTH-1:0]   ic_req_addr,
    output logic                    ic_req_ready,
    output logic [DATA_WIDTH-1:0]   ic_rdata,
    output logic                    ic_rvalid,
    output logic                    ic_done,
    input  logic                    dc_req_valid,
    input  logic                    dc_req_store,
    input  logic [ADDR_WIDTH-1:0]   dc_req_addr,
    output logic                    dc_req_ready,
    input  logic [DATA_WIDTH-1:0]   dc_wdata,
    output logic                    dc_wready,
    output logic [DATA_WIDTH-1:0]   dc_rdata,
    output logic                    dc_rvalid,
    output logic                    dc_done,
    output logic                    resp_err,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic                    m_axi_acvalid,
    input  logic [ADDR_WIDTH-1:0]   m_axi_acaddr,
    input  logic [3:0]              m_axi_acsnoop,
    input  logic [2:0]              m_axi_acprot,
    output logic                    m_axi_acready
);
    localparam int OFF = $clog2(BEATS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = {ADDR_WIDTH{1'b1}} << OFF;
    localparam logic [7:0] LEN  = 8'(BEATS - 1);
    localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  store_q, store_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  clr, inc, cnt_last, pick_dc;
    logic                  unused_in;

`ifdef ROUND_ROBIN_EN
    owner_e last_q, last_d;

    // Only contested grants move the pointer, so a lone request never steals the next tie.
    assign pick_dc = dc_req_valid & (~ic_req_valid | (last_q == OWN_IC));
    always_comb last_d = (state_q == IDLE && ic_req_valid && dc_req_valid) ? (pick_dc ? OWN_DC : OWN_IC) : last_q;

    always_ff @(posedge clk) begin
        if (reset) last_q <= OWN_IC;
        else       last_q <= last_d;
    end
`else
    assign pick_dc = dc_req_valid;
`endif

    axi_beat_counter #(.BEATS(BEATS)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clr),
        .inc   (inc),
        .last  (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        store_d       = store_q;
        addr_d        = addr_q;
        err_d         = err_q;
        clr           = 1'b0;
        inc           = 1'b0;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        ic_rvalid     = 1'b0;
        dc_rvalid     = 1'b0;
        ic_done       = 1'b0;
        dc_done       = 1'b0;
        dc_wready     = 1'b0;
        resp_err      = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                clr   = 1'b1;
                if (pick_dc) begin
                    dc_req_ready = 1'b1;
                    owner_d      = OWN_DC;
                    store_d      = dc_req_store;
                    addr_d       = dc_req_addr & ALIGN;
                    state_d      = dc_req_store ? AW : AR;
                end else if (ic_req_valid) begin
                    ic_req_ready = 1'b1;
                    owner_d      = OWN_IC;
                    store_d      = 1'b0;
                    addr_d       = ic_req_addr & ALIGN;
                    state_d      = AR;
                end
            end
            AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = R;
            end
            R: begin
                // rlast closes the burst; the counter is informational here.
                m_axi_rready = 1'b1;
                inc          = m_axi_rvalid;
                err_d        = err_q | (m_axi_rvalid && m_axi_rresp != RESP_OKAY);
                ic_rvalid    = m_axi_rvalid && owner_q == OWN_IC;
                dc_rvalid    = m_axi_rvalid && owner_q == OWN_DC;
                if (m_axi_rvalid && m_axi_rlast) begin
                    ic_done  = owner_q == OWN_IC;
                    dc_done  = owner_q == OWN_DC;
                    resp_err = err_d;
                    state_d  = IDLE;
                end
            end
            AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_d = W;
            end
            W: begin
                m_axi_wvalid = store_q;
                m_axi_wlast  = cnt_last;
                dc_wready    = store_q & m_axi_wready;
                inc          = dc_wready;
                if (dc_wready && cnt_last) state_d = B;
            end
            B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    err_d    = err_q | (m_axi_bresp != RESP_OKAY);
                    dc_done  = 1'b1;
                    resp_err = err_d;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IC;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            store_q <= store_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    assign ic_rdata      = m_axi_rdata;
    assign dc_rdata      = m_axi_rdata;
    assign m_axi_arid    = owner_q == OWN_DC ? ID_WIDTH'(DC_ID) : ID_WIDTH'(IC_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = LEN;
    assign m_axi_arsize  = SIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_awid    = ID_WIDTH'(DC_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = LEN;
    assign m_axi_awsize  = SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_wdata   = dc_wdata;
    assign m_axi_wstrb   = '1;
    // Snoops are acknowledged and dropped; the caches are not kept coherent through this port.
    assign m_axi_acready = 1'b1;
    assign unused_in     = ^{m_axi_bid, m_axi_rid, m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop, m_axi_acprot};
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: directed scoreboard bench for cache_bus_arbiter (honours ROUND_ROBIN_EN).
module tb_cache_bus_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic ic_req_valid = 0, dc_req_valid = 0, dc_req_store = 0;
    logic [63:0] ic_req_addr = 0, dc_req_addr = 0, dc_wdata = 0;
    logic ic_req_ready, ic_rvalid, ic_done, dc_req_ready, dc_wready, dc_rvalid, dc_done, resp_err;
    logic [63:0] ic_rdata, dc_rdata;
    logic [12:0] awid, arid;
    logic [63:0] awaddr, araddr, wdata;
    logic [7:0] awlen, arlen, wstrb;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst;
    logic awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready, acready;
    logic [3:0] awcache, arcache;
    logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0, acvalid = 0;
    logic [1:0] bresp = 0, rresp = 0;
    logic [63:0] rdata = 0;

    int n_vec = 0, n_err = 0;
    logic [97:0] q_ar[$], q_aw[$];
    logic [72:0] q_w[$];
    logic [63:0] q_icr[$], q_dcr[$];
    logic [2:0]  q_done[$];
    logic [1:0]  q_gnt[$];

    cache_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req_valid(dc_req_valid), .dc_req_store(dc_req_store), .dc_req_addr(dc_req_addr),
        .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wready(dc_wready),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done), .resp_err(resp_err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(13'd1), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(13'd0), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_acvalid(acvalid), .m_axi_acaddr(64'h0000_0000_8000_0000), .m_axi_acsnoop(4'd0),
        .m_axi_acprot(3'd0), .m_axi_acready(acready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic miss(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected or missing event want expected event", nm);
    endtask

    function automatic logic [97:0] exp_a(input logic [63:0] a, input int id);
        return {a, 13'(id), 8'd3, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0};
    endfunction

    always @(negedge clk) begin
        if (arvalid && arready) begin
            if (q_ar.size() == 0) miss("ar");
            else chk("ar", {araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot}, q_ar.pop_front());
        end
        if (awvalid && awready) begin
            if (q_aw.size() == 0) miss("aw");
            else chk("aw", {awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot}, q_aw.pop_front());
        end
        if (wvalid && wready) begin
            if (q_w.size() == 0) miss("w_beat");
            else chk("w_beat", {wdata, wlast, wstrb}, q_w.pop_front());
        end
        if (wvalid || dc_wready) chk("dc_wready", dc_wready, wvalid & wready);
        if (ic_rvalid) begin
            if (q_icr.size() == 0) miss("ic_rdata");
            else chk("ic_rdata", ic_rdata, q_icr.pop_front());
        end
        if (dc_rvalid) begin
            if (q_dcr.size() == 0) miss("dc_rdata");
            else chk("dc_rdata", dc_rdata, q_dcr.pop_front());
        end
        if (ic_done || dc_done) begin
            if (q_done.size() == 0) miss("done");
            else chk("done", {ic_done, dc_done, resp_err}, q_done.pop_front());
        end else if (resp_err) miss("resp_err");
        if (ic_req_ready || dc_req_ready) begin
            if (q_gnt.size() == 0) miss("grant");
            else chk("grant", {ic_req_ready, dc_req_ready}, q_gnt.pop_front());
        end
        if (acvalid) chk("acready", acready, 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string nm);
        chk(nm, {arvalid, awvalid, wvalid, rready, bready, ic_req_ready, dc_req_ready,
                 ic_rvalid, dc_rvalid, ic_done, dc_done, dc_wready, resp_err}, 13'd0);
        chk("acready_idle", acready, 1'b1);
    endtask

    task automatic wait_gnt(input bit dc);
        #1;
        for (int t = 0; t < 20 && !(dc ? dc_req_ready : ic_req_ready); t++) step();
        if (!(dc ? dc_req_ready : ic_req_ready)) miss("grant_timeout");
        step();
    endtask

    task automatic req(input bit dc, input bit store, input logic [63:0] a);
        q_gnt.push_back(dc ? 2'b01 : 2'b10);
        if (dc) begin
            dc_req_valid = 1; dc_req_store = store; dc_req_addr = a;
        end else begin
            ic_req_valid = 1; ic_req_addr = a;
        end
        wait_gnt(dc);
        if (dc) dc_req_valid = 0;
        else ic_req_valid = 0;
    endtask

    task automatic ar_hs();
        for (int t = 0; t < 20 && !arvalid; t++) step();
        if (!arvalid) miss("ar_timeout");
        step();
        arready = 1;
        step();
        arready = 0;
    endtask

    task automatic fill(input bit dc, input logic [63:0] ea, input logic [63:0] base, input int errbeat);
        q_ar.push_back(exp_a(ea, dc ? 1 : 0));
        ar_hs();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                rvalid = 0;
                step();
            end
            rvalid = 1;
            rdata  = base + 64'(k);
            rresp  = (k == errbeat) ? 2'b10 : 2'b00;
            rlast  = (k == 3);
            if (dc) q_dcr.push_back(base + 64'(k));
            else q_icr.push_back(base + 64'(k));
            if (k == 3) q_done.push_back({!dc, dc, errbeat >= 0});
            step();
        end
        rvalid = 0; rlast = 0; rresp = 0;
    endtask

    task automatic tie(input bit wdc);
        q_gnt.push_back(wdc ? 2'b01 : 2'b10);
        q_gnt.push_back(wdc ? 2'b10 : 2'b01);
        ic_req_valid = 1; ic_req_addr = 64'h4000_0008;
        dc_req_valid = 1; dc_req_store = 0; dc_req_addr = 64'h3000_0020;
        wait_gnt(wdc);
        if (wdc) dc_req_valid = 0;
        else ic_req_valid = 0;
        if (wdc) fill(1, 64'h3000_0020, 64'hC300_0000_0000_0000, -1);
        else fill(0, 64'h4000_0000, 64'hC400_0000_0000_0000, -1);
        wait_gnt(!wdc);
        if (wdc) ic_req_valid = 0;
        else dc_req_valid = 0;
        if (wdc) fill(0, 64'h4000_0000, 64'hC400_0000_0000_0000, -1);
        else fill(1, 64'h3000_0020, 64'hC300_0000_0000_0000, -1);
    endtask

    initial begin
        bit [7:0] wpat;
        int k, cyc;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        idle_chk("reset_idle");

        // I-cache fill from an unaligned address
        req(0, 0, 64'h1000_0013);
        fill(0, 64'h1000_0000, 64'hA000_0000_0000_0000, -1);

        // D-cache write-back with AW stall, toggled wready and snoop traffic
        acvalid = 1;
        req(1, 1, 64'h2000_0040);
        q_aw.push_back(exp_a(64'h2000_0040, 1));
        for (int j = 0; j < 4; j++) q_w.push_back({64'hD000_0000_0000_0000 + 64'(j), j == 3, 8'hFF});
        for (int t = 0; t < 20 && !awvalid; t++) step();
        if (!awvalid) miss("aw_timeout");
        repeat (3) step();
        awready = 1;
        step();
        awready = 0;
        wpat = 8'b1001_0110;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            wready   = wpat[cyc % 8];
            dc_wdata = 64'hD000_0000_0000_0000 + 64'(k);
            acvalid  = cyc[0];
            #1;
            if (dc_wready) begin
                step();
                k++;
            end else step();
            cyc++;
        end
        if (k < 4) miss("w_timeout");
        wready = 0;
        acvalid = 1;
        for (int t = 0; t < 20 && !bready; t++) step();
        if (!bready) miss("b_timeout");
        step();
        q_done.push_back(3'b010);
        bvalid = 1;
        step();
        bvalid = 0;
        acvalid = 0;

        // simultaneous requests, then a repeat tie
        tie(1);
`ifdef ROUND_ROBIN_EN
        tie(0);
`else
        tie(1);
`endif

        // error on beat 2 of a D-cache fill, clean transaction afterwards
        req(1, 0, 64'h5000_0000);
        fill(1, 64'h5000_0000, 64'hE500_0000_0000_0000, 1);
        req(0, 0, 64'h6000_0010);
        fill(0, 64'h6000_0000, 64'hE600_0000_0000_0000, -1);

        // reset after the first beat of a burst
        req(0, 0, 64'h7000_0000);
        q_ar.push_back(exp_a(64'h7000_0000, 0));
        ar_hs();
        rvalid = 1;
        rdata  = 64'hF700_0000_0000_0000;
        q_icr.push_back(64'hF700_0000_0000_0000);
        step();
        rvalid = 0;
        reset = 1;
        step();
        reset = 0;
        idle_chk("reset_midburst");
        req(0, 0, 64'h7000_0048);
        fill(0, 64'h7000_0040, 64'hF740_0000_0000_0000, -1);

        repeat (5) step();
        chk("left_ar", q_ar.size(), 0);
        chk("left_aw", q_aw.size(), 0);
        chk("left_w", q_w.size(), 0);
        chk("left_icr", q_icr.size(), 0);
        chk("left_dcr", q_dcr.size(), 0);
        chk("left_done", q_done.size(), 0);
        chk("left_gnt", q_gnt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
